// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundles the two requester ports, the shared mem_system port
// and the sticky error flag of mem_arbiter.
//   Fetch requester : i_req, i_addr -> i_rdata, i_done, i_stall
//   Data requester  : d_rd, d_wr, d_addr, d_wdata -> d_rdata, d_done, d_stall
//   mem_system      : mem_addr, mem_wdata, mem_rd, mem_wr <- mem_rdata, mem_done, mem_err
//   Status          : err
// modport master is the arbiter's view; modport slave is the view of the
// requesters and mem_system combined.
interface mem_arbiter_if;
    logic        i_req;
    logic [15:0] i_addr;
    logic [15:0] i_rdata;
    logic        i_done;
    logic        i_stall;

    logic        d_rd;
    logic        d_wr;
    logic [15:0] d_addr;
    logic [15:0] d_wdata;
    logic [15:0] d_rdata;
    logic        d_done;
    logic        d_stall;

    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_rd;
    logic        mem_wr;
    logic [15:0] mem_rdata;
    logic        mem_done;
    logic        mem_err;

    logic        err;

    modport master (
        input  i_req, i_addr, d_rd, d_wr, d_addr, d_wdata, mem_rdata, mem_done, mem_err,
        output i_rdata, i_done, i_stall, d_rdata, d_done, d_stall,
        output mem_addr, mem_wdata, mem_rd, mem_wr, err
    );

    modport slave (
        output i_req, i_addr, d_rd, d_wr, d_addr, d_wdata, mem_rdata, mem_done, mem_err,
        input  i_rdata, i_done, i_stall, d_rdata, d_done, d_stall,
        input  mem_addr, mem_wdata, mem_rd, mem_wr, err
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one mem_system port between instruction fetch and the
// memory stage. The winning request is latched into holding registers and
// driven until mem_done, then a one-cycle done pulse with registered read data
// is returned. Ties alternate between requesters. A watchdog and error latch
// provide a sticky fault flag.
// Ports:
//   clk    - clock, rising edge
//   rst    - asynchronous active-high reset
//   bus_io - requester, mem_system and status signals (see mem_arbiter_if)
module mem_arbiter #(
    parameter int unsigned WD_BITS = 8
) (
    input logic          clk,
    input logic          rst,
    mem_arbiter_if.master bus_io
);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StBusyI = 2'd1;
    localparam logic [1:0] StBusyD = 2'd2;
    localparam logic [1:0] StResp  = 2'd3;

    // Counter value during the busy cycle in which it reaches all-ones, i.e.
    // the (2^WD_BITS - 1)-th busy cycle without mem_done.
    localparam logic [WD_BITS-1:0] WdFire = {{(WD_BITS-1){1'b1}}, 1'b0};

    logic [1:0]         state_q, state_d;
    logic               last_d_q, last_d_d;   // 1: last grant went to the data stage
    logic [15:0]        addr_q, addr_d;
    logic [15:0]        wdata_q, wdata_d;
    logic               rd_q, rd_d;
    logic               wr_q, wr_d;
    logic [WD_BITS-1:0] wd_q, wd_d;
    logic [15:0]        i_rdata_q, i_rdata_d;
    logic [15:0]        d_rdata_q, d_rdata_d;
    logic               err_q, err_d;

    logic d_req;
    logic busy;

    assign d_req = bus_io.d_rd | bus_io.d_wr;
    assign busy  = (state_q == StBusyI) || (state_q == StBusyD);

    always_comb begin
        state_d   = state_q;
        last_d_d  = last_d_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rd_d      = rd_q;
        wr_d      = wr_q;
        wd_d      = wd_q;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;
        err_d     = err_q;

        case (state_q)
            StIdle: begin
                if (bus_io.d_rd && bus_io.d_wr) begin
                    err_d = 1'b1;
                end
                // Data wins when alone, or on a tie when fetch was served last.
                if (d_req && (!bus_io.i_req || !last_d_q)) begin
                    state_d  = StBusyD;
                    last_d_d = 1'b1;
                    addr_d   = bus_io.d_addr;
                    wdata_d  = bus_io.d_wdata;
                    rd_d     = bus_io.d_rd & ~bus_io.d_wr;  // rd+wr together acts as a write
                    wr_d     = bus_io.d_wr;
                    wd_d     = '0;
                end else if (bus_io.i_req) begin
                    state_d  = StBusyI;
                    last_d_d = 1'b0;
                    addr_d   = bus_io.i_addr;
                    wdata_d  = 16'h0000;
                    rd_d     = 1'b1;
                    wr_d     = 1'b0;
                    wd_d     = '0;
                end
            end

            StBusyI, StBusyD: begin
                if (bus_io.mem_err) begin
                    err_d = 1'b1;
                end
                if (bus_io.mem_done) begin
                    if (state_q == StBusyI) begin
                        i_rdata_d = bus_io.mem_rdata;
                    end else begin
                        d_rdata_d = bus_io.mem_rdata;
                    end
                    state_d = StResp;
                end else if (wd_q == WdFire) begin
                    err_d = 1'b1;
                    if (state_q == StBusyI) begin
                        i_rdata_d = 16'h0000;
                    end else begin
                        d_rdata_d = 16'h0000;
                    end
                    state_d = StResp;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end

            StResp: begin
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            last_d_q  <= 1'b0;
            addr_q    <= 16'h0000;
            wdata_q   <= 16'h0000;
            rd_q      <= 1'b0;
            wr_q      <= 1'b0;
            wd_q      <= '0;
            i_rdata_q <= 16'h0000;
            d_rdata_q <= 16'h0000;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_d_q  <= last_d_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rd_q      <= rd_d;
            wr_q      <= wr_d;
            wd_q      <= wd_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
            err_q     <= err_d;
        end
    end

    // Address/data hold their last value outside busy; strobes only while busy.
    assign bus_io.mem_addr  = addr_q;
    assign bus_io.mem_wdata = wdata_q;
    assign bus_io.mem_rd    = busy & rd_q;
    assign bus_io.mem_wr    = busy & wr_q;

    // RESP lasts one cycle, so these are single-cycle pulses to the winner.
    assign bus_io.i_done  = (state_q == StResp) & ~last_d_q;
    assign bus_io.d_done  = (state_q == StResp) & last_d_q;
    assign bus_io.i_rdata = i_rdata_q;
    assign bus_io.d_rdata = d_rdata_q;
    assign bus_io.i_stall = bus_io.i_req & ~bus_io.i_done;
    assign bus_io.d_stall = d_req & ~bus_io.d_done;
    assign bus_io.err     = err_q;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single `mem_system` data-memory port between the instruction-fetch requester and the memory-stage requester of the pipelined processor. Holds the selected request stable until `mem_system` signals completion, then returns a one-cycle done pulse and registered read data to the winning requester. Arbitration alternates on contention, so neither stage starves. A watchdog and error latch give the pipeline a sticky fault indication.

## Interface
- `WD_BITS`, 8: watchdog counter width; timeout fires after 2^WD_BITS − 1 busy cycles.
- `clk` in 1: system clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `i_req` in 1: fetch read request, held until `i_done`.
- `i_addr` in 16: fetch address.
- `i_rdata` out 16: fetch read data, valid when `i_done`.
- `i_done` out 1: one-cycle fetch completion pulse.
- `i_stall` out 1: `i_req & ~i_done`.
- `d_rd`, `d_wr` in 1 each: memory-stage read/write request, held until `d_done`.
- `d_addr` in 16: data address.
- `d_wdata` in 16: store data.
- `d_rdata` out 16: load data, valid when `d_done`.
- `d_done` out 1: one-cycle data completion pulse.
- `d_stall` out 1: `(d_rd|d_wr) & ~d_done`.
- `mem_addr` out 16: to `mem_system` Addr.
- `mem_wdata` out 16: to `mem_system` DataIn.
- `mem_rd`, `mem_wr` out 1 each: to `mem_system` Rd/Wr.
- `mem_rdata` in 16: from `mem_system` DataOut.
- `mem_done` in 1: from `mem_system` Done.
- `mem_err` in 1: from `mem_system` err.
- `err` out 1: sticky fault flag.

## Operation
- States: IDLE, BUSY_I, BUSY_D, RESP. Reset value is IDLE.
- **IDLE, arbitration:**
  - If only the data request (`d_rd|d_wr`) is pending, go to BUSY_D.
  - If only `i_req` is pending, go to BUSY_I.
  - If both are pending, grant the requester opposite to `last_grant`.
  - `last_grant` resets to I, so the data stage wins the first tie.
  - On a transition, latch addr/wdata/rd/wr of the winner into holding registers and update `last_grant`.
- **BUSY_x:**
  - Drive `mem_addr`, `mem_wdata`, `mem_rd`, `mem_wr` from the holding registers.
  - The fetch path uses `mem_rd=1`, `mem_wr=0`, `mem_wdata=0`.
  - Requester inputs are ignored while busy; a change is not forwarded.
  - On `mem_done=1`: capture `mem_rdata` into the winner's rdata register and go to RESP.
- **RESP:**
  - `mem_rd=mem_wr=0`.
  - Pulse the winner's done for exactly this cycle.
  - Ignore all requests, then go to IDLE.
  - Guarantees at least one deasserted Rd/Wr cycle between memory operations.
- **Idle outputs:** in IDLE and RESP, `mem_addr`/`mem_wdata` hold their last values and `mem_rd=mem_wr=0`.
- **Read data:** `i_rdata`/`d_rdata` hold their last captured value until the next capture. A store captures `mem_rdata` too; its value is don't-care.
- **Watchdog:**
  - A WD_BITS counter clears on entry to BUSY_x and increments each busy cycle.
  - At all-ones without `mem_done`: set `err`, load rdata with 0x0000, go to RESP. The requester still gets its done pulse.
- **Errors:** `err` is set by any of the following, and clears only on `rst`:
  - `mem_err` during BUSY_x;
  - `d_rd & d_wr` both high in IDLE, in which case that request is treated as a write;
  - the watchdog timeout.
- **Reset mid-operation:** `rst` forces IDLE, clears all registers and outputs to 0 and `last_grant` to I. An in-flight `mem_system` access is abandoned.

## Timing
- Reset values:
  - all outputs 0, including the `mem_*` outputs, `i_done`/`d_done`, `i_rdata`/`d_rdata` and `err`;
  - `i_stall`/`d_stall` follow their combinational equations.
- Request accepted in IDLE at cycle N; `mem_rd`/`mem_wr` asserted from cycle N+1.
- If `mem_done` is high in cycle M, then:
  - done and rdata are presented at M+1;
  - IDLE at M+2.
- Minimum request-to-done latency is 2 cycles (`mem_done` in N+1). Back-to-back service period is `mem_done` latency + 2.
- A requester sees its done at edge M+1 and may present its next request in M+2. It is arbitrated in M+2.
- Stall outputs are combinational from the requests and done. There is no registered path from requester input to `mem_*` except the IDLE→BUSY latch.

## Test plan
- **Single read:** `i_req`, `i_addr=0x0040`, `mem_done` at N+3 with `mem_rdata=0xBEEF`. Expect `mem_rd=1` in N+1..N+3, `i_done=1` and `i_rdata=0xBEEF` in N+4, `mem_rd=0` in N+4.
- **Contention:** `i_req` and `d_wr` asserted together at reset exit, `d_addr=0x0100`, `d_wdata=0x1234`. Data is served first (`mem_wr=1`, `mem_addr=0x0100`, `mem_wdata=0x1234`), then fetch. Repeat the tie: fetch wins the second tie.
- **Continuous requests:** both requesters request continuously for 20 operations. Grants strictly alternate D,I,D,I. `mem_rd|mem_wr` is low for at least one cycle between operations.
- **Watchdog:** `d_rd` with `mem_done` held 0. Expect `err=1` and `d_done` with `d_rdata=0x0000` after 255 busy cycles. `err` stays 1 through later good operations until `rst`.
- **Memory error:** `mem_err=1` pulsed during BUSY_I. Expect `err=1`; the operation still completes normally on `mem_done`.
- **Reset mid-operation:** assert `rst` asynchronously in mid-BUSY_D. All outputs go to 0 immediately. After release, a fresh `i_req` and `d_rd` tie is granted to data.
